radix_converter: RTL

- Sequential, parametrised successor to the team's combinational 4-bit number-system converter.
- Accepts an IN_W-bit unsigned value plus a radix select over a valid/ready handshake.
- Produces the value as packed 4-bit digits in binary, octal, decimal or hexadecimal, one digit per clock, by iterative divide/modulo.
- Sits between datapath/register sources and display/UART formatting logic.

---
 rtl/radix_converter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/radix_converter.sv
// Iterative radix converter: unsigned value -> packed 4-bit digits in base 2/8/10/16.
// Latency: result valid D cycles after accept (D = significant digits, min 1).
// Backpressure: result held in DONE until out_ready; no new accept until back in IDLE.
module radix_converter #(
  parameter int IN_W  = 16,
  parameter int NDIG  = 16,
  parameter int CNT_W = $clog2(NDIG + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_value,
  input  logic [1:0]            in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*NDIG-1:0]     out_digits,
  output logic [CNT_W-1:0]      out_ndig,
  output logic [1:0]            out_mode
);

  // Working width is at least one nibble so the mask/shift slices below are always legal.
  localparam int WW    = (IN_W < 4) ? 4 : IN_W;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  // Binary needs one slot per input bit; anything smaller cannot hold every result.
  generate
    if (NDIG < IN_W) begin : g_bad_ndig
      $error("radix_converter: NDIG must be >= IN_W");
    end
    if (CNT_W != $clog2(NDIG + 1)) begin : g_bad_cnt_w
      $error("radix_converter: CNT_W is derived from NDIG and must not be overridden");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic [IN_W-1:0]       r_work;
  logic [IDX_W-1:0]      r_idx;
  logic [4*NDIG-1:0]     r_digits;
  logic [CNT_W-1:0]      r_ndig;
  logic [1:0]            r_mode;

  logic [WW-1:0]         w_work_x;
  logic [WW-1:0]         w_quot_x;
  logic [IN_W-1:0]       w_quot;
  logic [3:0]            w_digit;
  logic                  w_last;
  logic                  w_accept;

  assign w_accept = (r_state == S_IDLE) && in_valid;

  // One digit step: power-of-two radices use mask/shift, decimal uses a constant divide.
  always_comb begin
    w_work_x = WW'(r_work);
    w_quot_x = '0;
    w_digit  = '0;
    case (r_mode)
      2'b00: begin
        w_digit  = {3'b000, w_work_x[0]};
        w_quot_x = w_work_x >> 1;
      end
      2'b01: begin
        w_digit  = {1'b0, w_work_x[2:0]};
        w_quot_x = w_work_x >> 3;
      end
      2'b10: begin
        w_quot_x = w_work_x / WW'(10);
        w_digit  = 4'(w_work_x % WW'(10));
      end
      default: begin
        w_digit  = w_work_x[3:0];
        w_quot_x = w_work_x >> 4;
      end
    endcase
    w_quot = IN_W'(w_quot_x);
    w_last = (w_quot == '0);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: accept, iterate until quotient reaches zero, wait for handshake.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_next = S_CONV;
      S_CONV: if (w_last) w_next = S_DONE;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded purely from state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE:  in_ready  = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Datapath: capture on accept, emit one digit per CONV cycle, hold everything otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_work   <= '0;
      r_idx    <= '0;
      r_digits <= '0;
      r_ndig   <= '0;
      r_mode   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_work   <= in_value;
            r_mode   <= in_mode;
            r_digits <= '0;
            r_idx    <= '0;
          end
        end
        S_CONV: begin
          r_digits[{r_idx, 2'b00} +: 4] <= w_digit;
          r_work                        <= w_quot;
          // Index stops on the last digit so it never walks past the top slot.
          if (w_last) begin
            r_ndig <= CNT_W'(r_idx) + CNT_W'(1);
          end else begin
            r_idx  <= r_idx + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out_digits = r_digits;
  assign out_ndig   = r_ndig;
  assign out_mode   = r_mode;

endmodule
